// File: rtl/rom_arb_pkg.sv
// Shared types and configuration defaults for the boot-loaded ROM arbiter.
// Holds the LOAD/RUN state encoding, response-owner IDs and address helpers.
package rom_arb_pkg;

    localparam int CFG_AW = 32;
    localparam int CFG_DW = 32;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/rom_arb_rr_wait_cnt.sv
// Saturating count of consecutive denied fetch cycles.
// The sat output is what lets the fetch port override load-store priority.
module rr_wait_cnt #(
    parameter int MAX = 4,
    parameter int CW  = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat = (cnt_q == CW'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rom_arb.sv
// Two-port read arbiter in front of a loader-filled ROM with a single read port.
// Load-store has priority; a starved fetch port is forced through after MAX_WAIT denials.
module rom_arb
    import rom_arb_pkg::*;
#(
    parameter int DW        = CFG_DW,
    parameter int AW        = CFG_AW,
    parameter int MAX_WAIT  = 4,
    parameter int BOOT_LOAD = 1
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,

    input  logic          ls_req,
    input  logic [AW-1:0] ls_addr,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,

    input  logic          ld_wen,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_done,

    output logic          rom_wen,
    output logic [AW-1:0] rom_w_addr,
    output logic [DW-1:0] rom_w_data,

    output logic          rom_ren,
    output logic [AW-1:0] rom_r_addr,
    input  logic [DW-1:0] rom_r_data,

    output logic          run
);

    // Handshake: a port holds x_req with a stable x_addr until x_gnt; the cycle with
    // x_req && x_gnt is the transfer, and x_rvalid (with x_rdata/x_err) follows exactly
    // one cycle later. There is no backpressure on responses.

    localparam state_e RST_STATE = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;

    state_e        state_q, state_d;
    logic          resp_vld_q, resp_vld_d;
    owner_e        resp_own_q, resp_own_d;
    logic          resp_err_q, resp_err_d;

    logic          wait_sat;
    logic          pick_vld;
    owner_e        pick_own;
    logic [AW-1:0] pick_addr;
    logic          collide;
    logic          misal;
    logic          grant;

    assign rom_wen    = ld_wen;
    assign rom_w_addr = ld_addr;
    assign rom_w_data = ld_data;

    always_comb begin
        state_d = state_q;
        if (state_q == ST_LOAD && ld_done) begin
            state_d = ST_RUN;
        end
    end

    // Winner selection happens first; a collision with a loader write then blocks the
    // winner outright instead of handing the slot to the other port.
    always_comb begin
        pick_vld  = 1'b0;
        pick_own  = OWN_LS;
        pick_addr = ls_addr;
        if (if_req && (wait_sat || !ls_req)) begin
            pick_vld  = 1'b1;
            pick_own  = OWN_IF;
            pick_addr = if_addr;
        end else if (ls_req) begin
            pick_vld  = 1'b1;
            pick_own  = OWN_LS;
            pick_addr = ls_addr;
        end
        collide = ld_wen && (ld_addr[AW-1:2] == pick_addr[AW-1:2]);
        misal   = is_misaligned(pick_addr[1:0]);
        grant   = (state_q == ST_RUN) && pick_vld && !collide;
    end

    assign if_gnt     = grant && (pick_own == OWN_IF);
    assign ls_gnt     = grant && (pick_own == OWN_LS);
    assign rom_ren    = grant && !misal;
    assign rom_r_addr = pick_addr;

    rr_wait_cnt #(
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (if_req && !if_gnt),
        .clr  (if_gnt),
        .sat  (wait_sat)
    );

    always_comb begin
        resp_vld_d = grant;
        resp_own_d = pick_own;
        resp_err_d = misal;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RST_STATE;
            resp_vld_q <= 1'b0;
            resp_own_q <= OWN_IF;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_vld_q <= resp_vld_d;
            resp_own_q <= resp_own_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Misaligned grants never touched the ROM, so their data is forced to zero.
    assign if_rvalid = resp_vld_q && (resp_own_q == OWN_IF);
    assign ls_rvalid = resp_vld_q && (resp_own_q == OWN_LS);
    assign if_err    = if_rvalid && resp_err_q;
    assign ls_err    = ls_rvalid && resp_err_q;
    assign if_rdata  = (if_rvalid && !resp_err_q) ? rom_r_data : '0;
    assign ls_rdata  = (ls_rvalid && !resp_err_q) ? rom_r_data : '0;

    assign run = (state_q == ST_RUN);

endmodule

// File: tb/tb_rom_arb.sv
// Bench for rom_arb: one-cycle vector table plus hand-built sequences, with a
// response scoreboard fed from a shadow copy of everything the loader wrote.
module tb_rom_arb;

    localparam int DW = 32;
    localparam int AW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          if_req, ls_req, ld_wen, ld_done;
    logic [AW-1:0] if_addr, ls_addr, ld_addr;
    logic [DW-1:0] ld_data;
    logic          if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
    logic [DW-1:0] if_rdata, ls_rdata;
    logic          rom_wen, rom_ren, run;
    logic [AW-1:0] rom_w_addr, rom_r_addr;
    logic [DW-1:0] rom_w_data;
    logic [DW-1:0] rom_r_data = '0;

    rom_arb #(.DW(DW), .AW(AW), .MAX_WAIT(4), .BOOT_LOAD(1)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
        .rom_wen(rom_wen), .rom_w_addr(rom_w_addr), .rom_w_data(rom_w_data),
        .rom_ren(rom_ren), .rom_r_addr(rom_r_addr), .rom_r_data(rom_r_data),
        .run(run)
    );

    // ROM behavioural model: 64 words, read data one cycle after rom_ren.
    logic [DW-1:0] rom_mem [64] = '{default: '0};
    always @(posedge clk) begin
        if (rom_wen) rom_mem[rom_w_addr[7:2]] <= rom_w_data;
        if (rom_ren) rom_r_data <= rom_mem[rom_r_addr[7:2]];
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] shadow [64] = '{default: '0};
    logic [DW+1:0] exp_q [$];   // {err, owner(0=if,1=ls), data}
    bit            resp_due = 1'b0;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic          if_req;
        logic [AW-1:0] if_addr;
        logic          ls_req;
        logic [AW-1:0] ls_addr;
        logic          ld_wen;
        logic [AW-1:0] ld_addr;
        logic [DW-1:0] ld_data;
        logic          ld_done;
        logic          e_if;
        logic          e_ls;
        logic          e_ren;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [AW-1:0] ia,
                                input logic lr, input logic [AW-1:0] la,
                                input logic w, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic d,
                                input logic eif, input logic els, input logic eren);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_addr = la;
        v.ld_wen = w; v.ld_addr = wa; v.ld_data = wd; v.ld_done = d;
        v.e_if = eif; v.e_ls = els; v.e_ren = eren;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver: one cycle per vector ----------------
    task automatic run_vec(input vec_t v, input string name);
        logic [DW+1:0] e;
        logic [AW-1:0] ga;
        logic          gerr;
        @(posedge clk); #1;
        if_req = v.if_req; if_addr = v.if_addr;
        ls_req = v.ls_req; ls_addr = v.ls_addr;
        ld_wen = v.ld_wen; ld_addr = v.ld_addr; ld_data = v.ld_data;
        ld_done = v.ld_done;
        @(negedge clk);
        if (resp_due) begin
            e = exp_q.pop_front();
            resp_due = 1'b0;
            chk({name, ":if_rvalid"}, if_rvalid, e[DW] == 1'b0);
            chk({name, ":ls_rvalid"}, ls_rvalid, e[DW] == 1'b1);
            if (e[DW] == 1'b0) begin
                chk({name, ":if_rdata"}, if_rdata, e[DW-1:0]);
                chk({name, ":if_err"}, if_err, e[DW+1]);
            end else begin
                chk({name, ":ls_rdata"}, ls_rdata, e[DW-1:0]);
                chk({name, ":ls_err"}, ls_err, e[DW+1]);
            end
        end else begin
            chk({name, ":if_rvalid_idle"}, if_rvalid, 1'b0);
            chk({name, ":ls_rvalid_idle"}, ls_rvalid, 1'b0);
        end
        chk({name, ":if_gnt"}, if_gnt, v.e_if);
        chk({name, ":ls_gnt"}, ls_gnt, v.e_ls);
        chk({name, ":rom_ren"}, rom_ren, v.e_ren);
        chk({name, ":rom_wen"}, rom_wen, v.ld_wen);
        if (v.ld_wen) begin
            chk({name, ":rom_w_addr"}, rom_w_addr, v.ld_addr);
            chk({name, ":rom_w_data"}, rom_w_data, v.ld_data);
        end
        if (v.e_if || v.e_ls) begin
            ga   = v.e_if ? v.if_addr : v.ls_addr;
            gerr = (ga[1:0] != 2'b00);
            if (!gerr) chk({name, ":rom_r_addr"}, rom_r_addr, ga);
            exp_q.push_back({gerr, v.e_ls, gerr ? {DW{1'b0}} : shadow[ga[7:2]]});
            resp_due = 1'b1;
        end
        if (v.ld_wen) shadow[v.ld_addr[7:2]] = v.ld_data;
    endtask

    vec_t  tbl [11];
    string tname [11];

    initial begin
        rstn = 1'b0;
        if_req = 0; ls_req = 0; ld_wen = 0; ld_done = 0;
        if_addr = '0; ls_addr = '0; ld_addr = '0; ld_data = '0;

        // Reset state
        #2;
        chk("rst:if_gnt", if_gnt, 1'b0);
        chk("rst:ls_gnt", ls_gnt, 1'b0);
        chk("rst:if_rvalid", if_rvalid, 1'b0);
        chk("rst:ls_rvalid", ls_rvalid, 1'b0);
        chk("rst:if_err", if_err, 1'b0);
        chk("rst:ls_err", ls_err, 1'b0);
        chk("rst:if_rdata", if_rdata, 32'h0);
        chk("rst:ls_rdata", ls_rdata, 32'h0);
        chk("rst:rom_ren", rom_ren, 1'b0);
        chk("rst:run", run, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // LOAD: fetch held at 0x4 is never granted while the loader fills the ROM
        run_vec(mk(1, 32'h4, 0, 0, 1, 32'h0,  32'h13,       0, 0, 0, 0), "load_w0");
        run_vec(mk(1, 32'h4, 0, 0, 1, 32'h4,  32'h00100093, 0, 0, 0, 0), "load_w4");
        run_vec(mk(1, 32'h4, 0, 0, 1, 32'h8,  $urandom,     0, 0, 0, 0), "load_w8");
        run_vec(mk(1, 32'h4, 1, 32'h8, 1, 32'hC, $urandom,  0, 0, 0, 0), "load_wc");
        run_vec(mk(1, 32'h4, 0, 0, 1, 32'h10, $urandom,     0, 0, 0, 0), "load_w10");
        run_vec(mk(1, 32'h4, 0, 0, 1, 32'h14, $urandom,     0, 0, 0, 0), "load_w14");
        run_vec(mk(1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 0), "ld_done");
        chk("ld_done:run", run, 1'b0);
        run_vec(mk(1, 32'h4, 0, 0, 0, 0, 0, 0, 1, 0, 1), "first_fetch");
        chk("first_fetch:run", run, 1'b1);

        // Single-cycle arbitration table (fetch wait count noted per row)
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                          tname[0]  = "idle";
        tbl[1]  = mk(1, 32'h8, 0, 0, 0, 0, 0, 0, 1, 0, 1);                      tname[1]  = "if_only";
        tbl[2]  = mk(0, 0, 1, 32'hC, 0, 0, 0, 0, 0, 1, 1);                      tname[2]  = "ls_only";
        tbl[3]  = mk(1, 32'h0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 1);                  tname[3]  = "ls_prio";     // wait 1
        tbl[4]  = mk(0, 0, 1, 32'h5, 0, 0, 0, 0, 0, 1, 0);                      tname[4]  = "ls_misal";
        tbl[5]  = mk(1, 32'h6, 0, 0, 0, 0, 0, 0, 1, 0, 0);                      tname[5]  = "if_misal";    // wait 0
        tbl[6]  = mk(0, 0, 1, 32'h8, 1, 32'hA, 32'hCAFE0001, 0, 0, 0, 0);       tname[6]  = "ls_collide";
        tbl[7]  = mk(0, 0, 1, 32'h8, 0, 0, 0, 0, 0, 1, 1);                      tname[7]  = "ls_retry";
        tbl[8]  = mk(1, 32'h14, 1, 32'h10, 1, 32'h12, 32'h5A5A0002, 0, 0, 0, 0); tname[8] = "win_collide"; // wait 1
        tbl[9]  = mk(1, 32'h14, 1, 32'h10, 1, 32'h14, 32'hBEEF0003, 0, 0, 1, 1); tname[9] = "lose_collide"; // wait 2
        tbl[10] = mk(1, 32'h14, 0, 0, 0, 0, 0, 0, 1, 0, 1);                     tname[10] = "if_new_data"; // wait 0
        for (int i = 0; i < 11; i++) run_vec(tbl[i], tname[i]);

        // Starvation: both held 6 cycles, fetch forced through on the fifth
        for (int i = 0; i < 6; i++) begin
            run_vec(mk(1, 32'h0, 1, 32'h4, 0, 0, 0, 0, i == 4, i != 4, 1),
                    $sformatf("starve%0d", i));
        end
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "drain");

        // Reset lands while a load-store read is in flight
        run_vec(mk(0, 0, 1, 32'h8, 0, 0, 0, 0, 0, 1, 1), "pre_reset_gnt");
        rstn = 1'b0;
        exp_q.delete();
        resp_due = 1'b0;
        if_req = 0; ls_req = 0;
        #1;
        chk("mid_rst:ls_rvalid", ls_rvalid, 1'b0);
        chk("mid_rst:run", run, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("in_rst%0d:ls_rvalid", i), ls_rvalid, 1'b0);
        end
        @(posedge clk); #1 rstn = 1'b1;
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst0");
        chk("post_rst0:run", run, 1'b0);
        run_vec(mk(1, 32'h0, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0), "post_rst_load");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
